pcie_mwr_gen: RTL and testbench

PCIE_MWR_GEN -- requirements
Module: pcie_mwr_gen

---
 rtl/pcie_mwr_gen.sv | 222 ++++++++++++++++++++++
 tb/tb_pcie_mwr_gen.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcie_mwr_gen.sv
// PCIe Memory Write TLP generator: a small register window programs address, length,
// seed and tag; START emits a 3DW MWr header and an incrementing-dword payload into a FIFO.
module pcie_mwr_gen #(
  parameter int BAR_IDX = 1
) (
  input  logic        pcie_clk,
  input  logic        sys_rst_n,
  input  logic [7:0]  bus_num,
  input  logic [4:0]  dev_num,
  input  logic [2:0]  func_num,
  input  logic [6:0]  slv_bar_i,
  input  logic        slv_ce_i,
  input  logic        slv_we_i,
  input  logic [19:1] slv_adr_i,
  input  logic [15:0] slv_dat_i,
  input  logic [1:0]  slv_sel_i,
  output logic [15:0] slv_dat_o,
  output logic        mst_wr_en,
  input  logic        mst_full,
  output logic [17:0] mst_din,
  output logic        done_o
);

  // state  | meaning
  // S_IDLE | waiting for START
  // S_HDR  | pushing the six header halfwords
  // S_DATA | pushing 2*LEN payload halfwords
  // S_DONE | one cycle: pulse done_o, set sticky DONE
  typedef enum logic [1:0] {S_IDLE, S_HDR, S_DATA, S_DONE} state_t;

  state_t      r_state;
  logic [5:0]  r_cnt;
  logic        r_done;
  logic        r_err;
  logic [15:2] r_addr_lo;
  logic [15:0] r_addr_hi;
  logic [5:0]  r_len;
  logic [15:0] r_seed_lo;
  logic [15:0] r_seed_hi;
  logic [7:0]  r_tag;
  logic [31:2] r_s_addr;
  logic [5:0]  r_s_len;
  logic [31:0] r_s_dw;
  logic [7:0]  r_s_tag;
  logic [15:0] r_dat_o;

  logic        w_acc;
  logic        w_wr;
  logic        w_rd;
  logic [2:0]  w_idx;
  logic        w_wr_ctrl;
  logic        w_start;
  logic        w_len_ok;
  logic        w_busy;
  logic        w_push;
  logic        w_last_hdr;
  logic        w_last_dat;
  logic [6:0]  w_dat_words;
  logic [15:0] w_hw;
  logic [15:0] w_rdata;
  logic        w_unused;

  assign w_acc       = slv_ce_i & slv_bar_i[BAR_IDX];
  assign w_wr        = w_acc & slv_we_i;
  assign w_rd        = w_acc & ~slv_we_i;
  assign w_idx       = slv_adr_i[3:1];
  assign w_wr_ctrl   = w_wr && (w_idx == 3'd0) && slv_sel_i[0];
  assign w_start     = w_wr_ctrl && slv_dat_i[0];
  assign w_len_ok    = (r_len != 6'd0) && (r_len <= 6'd32);
  assign w_busy      = (r_state != S_IDLE);
  assign w_push      = ((r_state == S_HDR) || (r_state == S_DATA)) && !mst_full;
  assign w_dat_words = {r_s_len, 1'b0};
  assign w_last_hdr  = (r_cnt == 6'd5);
  assign w_last_dat  = ({1'b0, r_cnt} == (w_dat_words - 7'd1));
  assign w_unused    = ^{slv_adr_i[19:4], slv_bar_i};

  // Halfword is a pure function of state and counter, so it holds across a stall.
  always_comb begin
    w_hw = 16'h0000;
    if (r_state == S_HDR) begin
      case (r_cnt)
        6'd0:    w_hw = 16'h4000;
        6'd1:    w_hw = {10'b0, r_s_len};
        6'd2:    w_hw = {bus_num, dev_num, func_num};
        6'd3:    w_hw = {r_s_tag, (r_s_len == 6'd1) ? 4'h0 : 4'hF, 4'hF};
        6'd4:    w_hw = r_s_addr[31:16];
        6'd5:    w_hw = {r_s_addr[15:2], 2'b00};
        default: w_hw = 16'h0000;
      endcase
    end else if (r_state == S_DATA) begin
      w_hw = r_cnt[0] ? r_s_dw[15:0] : r_s_dw[31:16];
    end
  end

  assign mst_wr_en = w_push;
  assign mst_din   = {w_push && (r_state == S_HDR) && (r_cnt == 6'd0),
                      w_push && (r_state == S_DATA) && w_last_dat,
                      w_hw};
  assign done_o    = (r_state == S_DONE);
  assign slv_dat_o = r_dat_o;

  always_comb begin
    w_rdata = 16'h0000;
    case (w_idx)
      3'd0:    w_rdata = {12'h000, r_err, r_done, w_busy, 1'b0};
      3'd1:    w_rdata = {r_addr_lo, 2'b00};
      3'd2:    w_rdata = r_addr_hi;
      3'd3:    w_rdata = {10'h000, r_len};
      3'd4:    w_rdata = r_seed_lo;
      3'd5:    w_rdata = r_seed_hi;
      3'd6:    w_rdata = {8'h00, r_tag};
      default: w_rdata = 16'h0000;
    endcase
  end

  always_ff @(posedge pcie_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_dat_o <= 16'h0000;
    end else if (w_rd) begin
      r_dat_o <= w_rdata;
    end
  end

  // Sticky status: a hardware set always wins over a same-cycle write-1-clear.
  always_ff @(posedge pcie_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      if (r_state == S_DONE)
        r_done <= 1'b1;
      else if (w_wr_ctrl && slv_dat_i[2])
        r_done <= 1'b0;
      if (w_start && !w_busy && !w_len_ok)
        r_err <= 1'b1;
      else if (w_wr_ctrl && slv_dat_i[3])
        r_err <= 1'b0;
    end
  end

  always_ff @(posedge pcie_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_addr_lo <= '0;
      r_addr_hi <= '0;
      r_len     <= '0;
      r_seed_lo <= '0;
      r_seed_hi <= '0;
      r_tag     <= '0;
    end else if (w_wr) begin
      case (w_idx)
        3'd1: begin
          if (slv_sel_i[0]) r_addr_lo[7:2]  <= slv_dat_i[7:2];
          if (slv_sel_i[1]) r_addr_lo[15:8] <= slv_dat_i[15:8];
        end
        3'd2: begin
          if (slv_sel_i[0]) r_addr_hi[7:0]  <= slv_dat_i[7:0];
          if (slv_sel_i[1]) r_addr_hi[15:8] <= slv_dat_i[15:8];
        end
        3'd3: if (slv_sel_i[0]) r_len <= slv_dat_i[5:0];
        3'd4: begin
          if (slv_sel_i[0]) r_seed_lo[7:0]  <= slv_dat_i[7:0];
          if (slv_sel_i[1]) r_seed_lo[15:8] <= slv_dat_i[15:8];
        end
        3'd5: begin
          if (slv_sel_i[0]) r_seed_hi[7:0]  <= slv_dat_i[7:0];
          if (slv_sel_i[1]) r_seed_hi[15:8] <= slv_dat_i[15:8];
        end
        3'd6: if (slv_sel_i[0]) r_tag <= slv_dat_i[7:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge pcie_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_s_addr <= '0;
      r_s_len  <= '0;
      r_s_dw   <= '0;
      r_s_tag  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start && w_len_ok) begin
            r_s_addr <= {r_addr_hi, r_addr_lo};
            r_s_len  <= r_len;
            r_s_dw   <= {r_seed_hi, r_seed_lo};
            r_s_tag  <= r_tag;
            r_cnt    <= '0;
            r_state  <= S_HDR;
          end
        end
        S_HDR: begin
          if (w_push) begin
            if (w_last_hdr) begin
              r_cnt   <= '0;
              r_state <= S_DATA;
            end else begin
              r_cnt <= r_cnt + 6'd1;
            end
          end
        end
        S_DATA: begin
          if (w_push) begin
            if (r_cnt[0])
              r_s_dw <= r_s_dw + 32'd1;
            if (w_last_dat) begin
              r_cnt   <= '0;
              r_state <= S_DONE;
            end else begin
              r_cnt <= r_cnt + 6'd1;
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pcie_mwr_gen.sv
// Bench for pcie_mwr_gen: register-programmed TLPs with random FIFO back-pressure,
// compared word-for-word against a TLP model built from the header/payload rules.
module tb_pcie_mwr_gen;
  localparam int BAR_IDX = 1;

  logic        pcie_clk = 1'b0;
  logic        sys_rst_n;
  logic [7:0]  bus_num;
  logic [4:0]  dev_num;
  logic [2:0]  func_num;
  logic [6:0]  slv_bar_i;
  logic        slv_ce_i;
  logic        slv_we_i;
  logic [19:1] slv_adr_i;
  logic [15:0] slv_dat_i;
  logic [1:0]  slv_sel_i;
  logic [15:0] slv_dat_o;
  logic        mst_wr_en;
  logic        mst_full;
  logic [17:0] mst_din;
  logic        done_o;

  pcie_mwr_gen #(.BAR_IDX(BAR_IDX)) dut (
    .pcie_clk(pcie_clk), .sys_rst_n(sys_rst_n),
    .bus_num(bus_num), .dev_num(dev_num), .func_num(func_num),
    .slv_bar_i(slv_bar_i), .slv_ce_i(slv_ce_i), .slv_we_i(slv_we_i),
    .slv_adr_i(slv_adr_i), .slv_dat_i(slv_dat_i), .slv_sel_i(slv_sel_i),
    .slv_dat_o(slv_dat_o), .mst_wr_en(mst_wr_en), .mst_full(mst_full),
    .mst_din(mst_din), .done_o(done_o)
  );

  always #5 pcie_clk = ~pcie_clk;

  int n_chk = 0;
  int n_pass = 0;
  int done_cnt = 0;
  int v_full = 0;
  int v_sopeop = 0;
  int v_hold = 0;
  bit rnd_full = 1'b0;
  bit in_tlp = 1'b0;
  bit have_stall = 1'b0;
  logic [15:0] stall_hw;
  logic [17:0] got[$];
  logic [17:0] exp_q[$];
  logic [15:0] rdat;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // FIFO-side monitor, sampled mid-cycle
  initial begin
    forever begin
      @(negedge pcie_clk);
      if (!sys_rst_n) begin
        in_tlp = 1'b0;
        have_stall = 1'b0;
      end
      if (mst_wr_en) begin
        if (mst_full) v_full++;
        if (have_stall && (mst_din[15:0] !== stall_hw)) v_hold++;
        have_stall = 1'b0;
        got.push_back(mst_din);
        if (mst_din[17]) in_tlp = 1'b1;
        if (mst_din[16]) in_tlp = 1'b0;
      end else begin
        if (mst_din[17:16] !== 2'b00) v_sopeop++;
        if (in_tlp && mst_full) begin
          if (have_stall && (mst_din[15:0] !== stall_hw)) v_hold++;
          stall_hw = mst_din[15:0];
          have_stall = 1'b1;
        end
      end
      if (done_o) done_cnt++;
    end
  end

  initial begin
    mst_full = 1'b0;
    forever begin
      @(posedge pcie_clk);
      #1;
      mst_full = rnd_full ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  end

  task automatic wr(input logic [2:0] idx, input logic [15:0] d,
                    input logic [1:0] sel = 2'b11, input logic bar_ok = 1'b1,
                    input logic ce = 1'b1);
    @(posedge pcie_clk);
    #1;
    slv_bar_i = 7'($urandom);
    slv_bar_i[BAR_IDX] = bar_ok;
    slv_adr_i = {16'($urandom), idx};
    slv_dat_i = d;
    slv_sel_i = sel;
    slv_we_i  = 1'b1;
    slv_ce_i  = ce;
    @(posedge pcie_clk);
    #1;
    slv_ce_i = 1'b0;
    slv_we_i = 1'b0;
  endtask

  task automatic rd(input logic [2:0] idx, output logic [15:0] d);
    @(posedge pcie_clk);
    #1;
    slv_bar_i = 7'($urandom);
    slv_bar_i[BAR_IDX] = 1'b1;
    slv_adr_i = {16'($urandom), idx};
    slv_sel_i = 2'($urandom);
    slv_we_i  = 1'b0;
    slv_ce_i  = 1'b1;
    @(posedge pcie_clk);
    #1;
    d = slv_dat_o;
    slv_ce_i = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [2:0] idx, input logic [15:0] e);
    logic [15:0] d;
    rd(idx, d);
    chk(tag, {16'h0, d}, {16'h0, e});
  endtask

  task automatic prog(input logic [31:0] a, input logic [5:0] len,
                      input logic [31:0] seed, input logic [7:0] tag);
    wr(3'd1, a[15:0]);
    wr(3'd2, a[31:16]);
    wr(3'd3, {10'h0, len});
    wr(3'd4, seed[15:0]);
    wr(3'd5, seed[31:16]);
    wr(3'd6, {8'h0, tag});
  endtask

  // Reference TLP: 3DW MWr header followed by dwords SEED+n, high half first.
  task automatic build_exp(input logic [31:0] a, input int len,
                           input logic [31:0] seed, input logic [7:0] tag);
    logic [31:0] d;
    logic [3:0]  last_be;
    exp_q.delete();
    last_be = (len == 1) ? 4'h0 : 4'hF;
    exp_q.push_back({2'b10, 16'h4000});
    exp_q.push_back({2'b00, 10'h000, 6'(len)});
    exp_q.push_back({2'b00, bus_num, dev_num, func_num});
    exp_q.push_back({2'b00, tag, last_be, 4'hF});
    exp_q.push_back({2'b00, a[31:16]});
    exp_q.push_back({2'b00, a[15:2], 2'b00});
    for (int n = 0; n < len; n++) begin
      d = seed + 32'(n);
      exp_q.push_back({2'b00, d[31:16]});
      exp_q.push_back({1'b0, (n == len - 1), d[15:0]});
    end
  endtask

  task automatic wait_done(input string name, input int budget);
    int  c0;
    bit  seen;
    c0 = done_cnt;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge pcie_clk);
      if (done_cnt != c0) begin
        seen = 1'b1;
        break;
      end
    end
    chk({name, "_done_seen"}, 32'(seen), 32'd1);
    repeat (4) @(posedge pcie_clk);
    chk({name, "_done_pulses"}, 32'(done_cnt - c0), 32'd1);
  endtask

  task automatic check_tlp(input string name);
    int n_sop;
    int n_eop;
    n_sop = 0;
    n_eop = 0;
    foreach (got[i]) begin
      if (got[i][17]) n_sop++;
      if (got[i][16]) n_eop++;
    end
    chk({name, "_nwords"}, 32'(got.size()), 32'(exp_q.size()));
    chk({name, "_nsop"}, 32'(n_sop), 32'd1);
    chk({name, "_neop"}, 32'(n_eop), 32'd1);
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      chk($sformatf("%s_w%0d", name, i), {14'h0, got[i]}, {14'h0, exp_q[i]});
  endtask

  task automatic rand_tlp(input string name);
    logic [31:0] a;
    logic [31:0] seed;
    logic [7:0]  tag;
    int          len;
    bus_num  = 8'($urandom);
    dev_num  = 5'($urandom);
    func_num = 3'($urandom);
    a    = $urandom;
    seed = $urandom;
    tag  = 8'($urandom);
    len  = $urandom_range(1, 32);
    prog(a, 6'(len), seed, tag);
    build_exp(a, len, seed, tag);
    got.delete();
    rnd_full = 1'b1;
    wr(3'd0, 16'h0001);
    wait_done(name, 2000);
    rnd_full = 1'b0;
    check_tlp(name);
    wr(3'd0, 16'h0004);
  endtask

  initial begin
    sys_rst_n = 1'b0;
    bus_num = 8'd1; dev_num = 5'd0; func_num = 3'd0;
    slv_bar_i = '0; slv_ce_i = 1'b0; slv_we_i = 1'b0;
    slv_adr_i = '0; slv_dat_i = '0; slv_sel_i = '0;
    #23;
    chk("rst_wr_en", 32'(mst_wr_en), 32'd0);
    chk("rst_din", 32'(mst_din), 32'd0);
    chk("rst_done_o", 32'(done_o), 32'd0);
    chk("rst_dat_o", 32'(slv_dat_o), 32'd0);
    @(posedge pcie_clk);
    #1;
    sys_rst_n = 1'b1;
    for (int r = 0; r < 8; r++) rd_chk($sformatf("rst_reg%0d", r), 3'(r), 16'h0000);

    // byte enables, masked fields, decode qualifiers
    wr(3'd2, 16'h1234);
    wr(3'd2, 16'hABCD, 2'b01);
    rd_chk("sel_lo", 3'd2, 16'h12CD);
    wr(3'd2, 16'hEF00, 2'b10);
    rd_chk("sel_hi", 3'd2, 16'hEFCD);
    wr(3'd1, 16'hFFFF);
    rd_chk("addr_lo_mask", 3'd1, 16'hFFFC);
    wr(3'd3, 16'hFFFF);
    rd_chk("len_mask", 3'd3, 16'h003F);
    wr(3'd6, 16'hFFFF);
    rd_chk("tag_mask", 3'd6, 16'h00FF);
    wr(3'd6, 16'h0033, 2'b11, 1'b0);
    wr(3'd6, 16'h0044, 2'b11, 1'b1, 1'b0);
    rd_chk("decode_gate", 3'd6, 16'h00FF);
    wr(3'd1, 16'h0000);
    chk("dat_o_hold", 32'(slv_dat_o), 32'h00FF);
    rd_chk("reg7", 3'd7, 16'h0000);
    wr(3'd0, 16'h0001, 2'b10);
    rd_chk("start_needs_sel0", 3'd0, 16'h0000);

    // scenario 1: LEN=1 boundary, lastBE=0
    bus_num = 8'd1; dev_num = 5'd0; func_num = 3'd0;
    prog(32'h0000_1000, 6'd1, 32'hDEAD_BEEF, 8'h05);
    exp_q = {18'h24000, 18'h00001, 18'h00100, 18'h0050F,
             18'h00000, 18'h01000, 18'h0DEAD, 18'h1BEEF};
    got.delete();
    wr(3'd0, 16'h0001);
    wait_done("s1", 200);
    check_tlp("s1");
    rd_chk("s1_ctrl", 3'd0, 16'h0004);
    wr(3'd0, 16'h0004);
    rd_chk("s1_ctrl_clr", 3'd0, 16'h0000);

    // scenario 2: seed wrap, DONE clear colliding with DONE set
    prog(32'h1234_5678, 6'd2, 32'hFFFF_FFFF, 8'hA5);
    exp_q = {18'h24000, 18'h00002, 18'h00100, 18'h0A5FF, 18'h01234,
             18'h05678, 18'h0FFFF, 18'h0FFFF, 18'h00000, 18'h10000};
    got.delete();
    wr(3'd0, 16'h0001);
    for (int i = 0; i < 100; i++) begin
      @(negedge pcie_clk);
      if (mst_wr_en && mst_din[16]) break;
    end
    wr(3'd0, 16'h0004);
    repeat (3) @(posedge pcie_clk);
    check_tlp("s2");
    rd_chk("s2_done_wins", 3'd0, 16'h0004);
    wr(3'd0, 16'h0004);

    // scenario 3: LEN=32 under back-pressure
    bus_num = 8'h3C; dev_num = 5'h11; func_num = 3'h5;
    prog(32'h8000_0FFC, 6'd32, 32'h0102_0304, 8'h7E);
    build_exp(32'h8000_0FFC, 32, 32'h0102_0304, 8'h7E);
    got.delete();
    rnd_full = 1'b1;
    wr(3'd0, 16'h0001);
    wait_done("s3", 2000);
    rnd_full = 1'b0;
    check_tlp("s3");
    wr(3'd0, 16'h0004);

    for (int k = 0; k < 4; k++) rand_tlp($sformatf("rnd%0d", k));

    // scenario 4: illegal lengths
    got.delete();
    wr(3'd3, 16'h0000);
    wr(3'd0, 16'h0001);
    repeat (5) @(posedge pcie_clk);
    rd_chk("s4_len0_err", 3'd0, 16'h0008);
    wr(3'd0, 16'h0008);
    rd_chk("s4_len0_clr", 3'd0, 16'h0000);
    wr(3'd3, 16'd33);
    wr(3'd0, 16'h0001);
    repeat (5) @(posedge pcie_clk);
    rd_chk("s4_len33_err", 3'd0, 16'h0008);
    chk("s4_no_push", 32'(got.size()), 32'd0);
    wr(3'd0, 16'h0008);
    rd_chk("s4_len33_clr", 3'd0, 16'h0000);

    // scenario 5a: START and register rewrites while busy
    prog(32'h0000_2000, 6'd20, 32'h0000_0100, 8'h42);
    build_exp(32'h0000_2000, 20, 32'h0000_0100, 8'h42);
    got.delete();
    wr(3'd0, 16'h0001);
    for (int i = 0; i < 100 && got.size() < 2; i++) @(posedge pcie_clk);
    wr(3'd3, 16'd9);
    wr(3'd5, 16'h1111);
    wr(3'd1, 16'h0000);
    wr(3'd0, 16'h0001);
    rd_chk("s5_busy", 3'd0, 16'h0002);
    wait_done("s5a", 500);
    repeat (20) @(posedge pcie_clk);
    check_tlp("s5a");
    wr(3'd0, 16'h0004);

    // scenario 5b: reset after four pushes
    prog(32'h0000_3000, 6'd8, 32'h5555_0000, 8'h01);
    build_exp(32'h0000_3000, 8, 32'h5555_0000, 8'h01);
    got.delete();
    wr(3'd0, 16'h0001);
    for (int i = 0; i < 200 && got.size() < 4; i++) begin
      @(posedge pcie_clk);
      #1;
    end
    sys_rst_n = 1'b0;
    #1;
    chk("s5b_wr_en", 32'(mst_wr_en), 32'd0);
    chk("s5b_din", 32'(mst_din), 32'd0);
    chk("s5b_dat_o", 32'(slv_dat_o), 32'd0);
    repeat (10) @(posedge pcie_clk);
    chk("s5b_pushes", 32'(got.size()), 32'd4);
    for (int i = 0; i < 4 && i < got.size(); i++)
      chk($sformatf("s5b_w%0d", i), {14'h0, got[i]}, {14'h0, exp_q[i]});
    #1;
    sys_rst_n = 1'b1;
    for (int r = 0; r < 8; r++) rd_chk($sformatf("s5b_reg%0d", r), 3'(r), 16'h0000);
    chk("s5b_after", 32'(got.size()), 32'd4);

    chk("push_while_full", 32'(v_full), 32'd0);
    chk("sopeop_idle", 32'(v_sopeop), 32'd0);
    chk("stall_hold", 32'(v_hold), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
